// File: rtl/ttt_pkg.sv
// Shared types for the TTT programming loader: instruction codes, frame header
// layout and the loader frame FSM states.
package ttt_pkg;

   localparam int INSTR_BITS     = 3;
   localparam int HDR_COUNT_BITS = 5;

   // Instruction codes carried in the frame header; codes 5..7 are reserved.
   typedef enum logic [INSTR_BITS-1:0] {
      INSTR_NOP             = 3'd0,
      INSTR_SET_GOOD_THRESH = 3'd1,
      INSTR_SET_BAD_THRESH  = 3'd2,
      INSTR_SET_DURATION    = 3'd3,
      INSTR_SET_OUTPUT      = 3'd4
   } instr_t;

   typedef enum logic [1:0] {
      IDLE,
      GET_PID,
      STREAM,
      DRAIN
   } loader_state_t;

   // A header instruction is usable only if it names a real core instruction;
   // NOP and the reserved codes make the whole frame invalid.
   function automatic logic is_valid_instr(input logic [INSTR_BITS-1:0] code);
      return (code >= 3'd1) && (code <= 3'd4);
   endfunction

endpackage

// File: rtl/ttt_program_loader.sv
// Byte-serial programming transmitter: parses host frames (header, processor id,
// payload bytes) and drives the cores' programming bus one word per cycle.
module ttt_program_loader
   import ttt_pkg::*;
#(
   parameter int NUM_PROCESSORS = 10,
   parameter int PROG_WIDTH     = 8
) (
   input  logic                              clock_fast,
   input  logic                              reset,
   input  logic [PROG_WIDTH-1:0]             in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [$clog2(NUM_PROCESSORS)-1:0] processor_id,
   output instr_t                            instruction,
   output logic [PROG_WIDTH-1:0]             prog_data,
   output logic                              hold,
   output logic                              frame_done,
   output logic                              frame_error
);

   localparam int PID_W = $clog2(NUM_PROCESSORS);
   localparam logic [PROG_WIDTH-1:0] NUM_PROC_LIMIT = PROG_WIDTH'(NUM_PROCESSORS);

   loader_state_t             state_q, state_d;
   logic [HDR_COUNT_BITS-1:0] count_q, count_d;
   logic [INSTR_BITS-1:0]     hdr_instr_q, hdr_instr_d;
   logic [PID_W-1:0]          pid_q, pid_d;
   logic                      in_ready_q, in_ready_d;
   logic [PID_W-1:0]          processor_id_q, processor_id_d;
   instr_t                    instruction_q, instruction_d;
   logic [PROG_WIDTH-1:0]     prog_data_q, prog_data_d;
   logic                      hold_q, hold_d;
   logic                      frame_done_q, frame_done_d;
   logic                      frame_error_q, frame_error_d;

   logic accept;
   logic frame_bad;
   logic finish;

   assign accept    = in_valid & in_ready_q;
   assign frame_bad = (in_data >= NUM_PROC_LIMIT) || !is_valid_instr(hdr_instr_q);

   // Frame parser: walks header, id and payload, and decides what lands on the
   // programming bus in the cycle after each accepted byte.
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      hdr_instr_d    = hdr_instr_q;
      pid_d          = pid_q;
      in_ready_d     = 1'b1;
      processor_id_d = processor_id_q;
      instruction_d  = INSTR_NOP;
      prog_data_d    = prog_data_q;
      frame_done_d   = 1'b0;
      frame_error_d  = 1'b0;
      finish         = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               hdr_instr_d = in_data[HDR_COUNT_BITS +: INSTR_BITS];
               count_d     = in_data[HDR_COUNT_BITS-1:0];
               state_d     = GET_PID;
            end
         end
         GET_PID: begin
            if (accept) begin
               pid_d = in_data[PID_W-1:0];
               if (frame_bad) begin
                  if (count_q == '0) begin
                     frame_error_d = 1'b1;
                     finish        = 1'b1;
                     state_d       = IDLE;
                  end else begin
                     state_d = DRAIN;
                  end
               end else if (count_q == '0) begin
                  instruction_d  = instr_t'(hdr_instr_q);
                  prog_data_d    = '0;
                  processor_id_d = in_data[PID_W-1:0];
                  frame_done_d   = 1'b1;
                  finish         = 1'b1;
                  state_d        = IDLE;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (accept) begin
               instruction_d  = instr_t'(hdr_instr_q);
               prog_data_d    = in_data;
               processor_id_d = pid_q;
               count_d        = count_q - 1'b1;
               if (count_q == HDR_COUNT_BITS'(1)) begin
                  frame_done_d = 1'b1;
                  finish       = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         DRAIN: begin
            if (accept) begin
               count_d = count_q - 1'b1;
               if (count_q == HDR_COUNT_BITS'(1)) begin
                  frame_error_d = 1'b1;
                  finish        = 1'b1;
                  state_d       = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // hold covers the whole frame plus the cycle showing its last word or
      // error pulse; a header accepted right then keeps it high.
      hold_d = (state_d != IDLE) || finish;
   end

   // State and registered outputs; reset returns the bus to its idle values at once.
   always_ff @(posedge clock_fast or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         count_q        <= '0;
         hdr_instr_q    <= '0;
         pid_q          <= '0;
         in_ready_q     <= 1'b0;
         processor_id_q <= '0;
         instruction_q  <= INSTR_NOP;
         prog_data_q    <= '0;
         hold_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_error_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         hdr_instr_q    <= hdr_instr_d;
         pid_q          <= pid_d;
         in_ready_q     <= in_ready_d;
         processor_id_q <= processor_id_d;
         instruction_q  <= instruction_d;
         prog_data_q    <= prog_data_d;
         hold_q         <= hold_d;
         frame_done_q   <= frame_done_d;
         frame_error_q  <= frame_error_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign processor_id = processor_id_q;
   assign instruction  = instruction_q;
   assign prog_data    = prog_data_q;
   assign hold         = hold_q;
   assign frame_done   = frame_done_q;
   assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_ttt_program_loader.sv
// Self-checking bench for ttt_program_loader: scenario tasks drive frames and
// push the words they expect; a negedge monitor pops and compares bus words.
module tb_ttt_program_loader;
   import ttt_pkg::*;

   logic       clock_fast;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] processor_id;
   instr_t     instruction;
   logic [7:0] prog_data;
   logic       hold;
   logic       frame_done;
   logic       frame_error;

   typedef struct packed {
      logic [2:0] instr;
      logic [3:0] id;
      logic [7:0] data;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   ttt_program_loader #(.NUM_PROCESSORS(10), .PROG_WIDTH(8)) dut (
      .clock_fast  (clock_fast),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .processor_id(processor_id),
      .instruction (instruction),
      .prog_data   (prog_data),
      .hold        (hold),
      .frame_done  (frame_done),
      .frame_error (frame_error)
   );

   // Free-running 10 ns clock.
   initial begin
      clock_fast = 1'b0;
      forever #5 clock_fast = ~clock_fast;
   end

   // Scoreboard consumer: every non-NOP bus word must match the next queued expectation.
   always @(negedge clock_fast) begin
      exp_t e;
      if (reset) begin
         if (instruction !== INSTR_NOP) begin
            checks++;
            if (sb.size() == 0) begin
               $display("[TB] FAIL unexpected_word: got instr=%0d id=%0d data=%h, required no word",
                        instruction, processor_id, prog_data);
            end else begin
               e = sb.pop_front();
               if ({3'(instruction), processor_id, prog_data, frame_done} !== e)
                  $display("[TB] FAIL bus_word: got instr=%0d id=%0d data=%h done=%b, required instr=%0d id=%0d data=%h done=%b",
                           instruction, processor_id, prog_data, frame_done, e.instr, e.id, e.data, e.done);
               else
                  passes++;
            end
         end else begin
            checks++;
            if (frame_done !== 1'b0)
               $display("[TB] FAIL done_without_word: got frame_done=%b, required 0", frame_done);
            else
               passes++;
         end
      end
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clock_fast);
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clock_fast);
   endtask

   task automatic expect_word(input logic [2:0] i, input logic [3:0] id, input logic [7:0] d, input logic done);
      exp_t e;
      e = '{instr: i, id: id, data: d, done: done};
      sb.push_back(e);
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clock_fast);
      checks++;
      if ({in_ready, hold, frame_done, frame_error, processor_id, prog_data, 3'(instruction)} !== 19'd0)
         $display("[TB] FAIL reset_values: got rdy=%b hold=%b done=%b err=%b id=%0d data=%h instr=%0d, required all 0",
                  in_ready, hold, frame_done, frame_error, processor_id, prog_data, instruction);
      else
         passes++;
      reset = 1'b1;
      @(negedge clock_fast);
      checks++;
      if (in_ready !== 1'b1)
         $display("[TB] FAIL ready_after_reset: got %b, required 1", in_ready);
      else
         passes++;
   endtask

   task automatic test_two_word();
      send_byte(8'h22);
      checks++;
      if (hold !== 1'b1) $display("[TB] FAIL hold_on_header: got %b, required 1", hold);
      else passes++;
      send_byte(8'd3);
      expect_word(3'd1, 4'd3, 8'h12, 1'b0);
      send_byte(8'h12);
      expect_word(3'd1, 4'd3, 8'h34, 1'b1);
      send_byte(8'h34);
      checks++;
      if (hold !== 1'b1) $display("[TB] FAIL hold_last_word: got %b, required 1", hold);
      else passes++;
      idle_cycle();
      checks++;
      if (hold !== 1'b0 || sb.size() != 0)
         $display("[TB] FAIL two_word_end: got hold=%b pending=%0d, required hold=0 pending=0", hold, sb.size());
      else passes++;
   endtask

   task automatic test_zero_count();
      send_byte(8'h60);
      expect_word(3'd3, 4'd9, 8'h00, 1'b1);
      send_byte(8'd9);
      checks++;
      if (frame_error !== 1'b0 || hold !== 1'b1)
         $display("[TB] FAIL zero_count_word: got err=%b hold=%b, required err=0 hold=1", frame_error, hold);
      else passes++;
      idle_cycle();
      checks++;
      if (hold !== 1'b0 || sb.size() != 0)
         $display("[TB] FAIL zero_count_end: got hold=%b pending=%0d, required hold=0 pending=0", hold, sb.size());
      else passes++;
   endtask

   task automatic test_bad_pid();
      send_byte(8'h43);
      send_byte(8'd10);
      send_byte(8'hA1);
      send_byte(8'hA2);
      checks++;
      if (frame_error !== 1'b0) $display("[TB] FAIL bad_pid_early_error: got %b, required 0", frame_error);
      else passes++;
      send_byte(8'hA3);
      checks++;
      if (frame_error !== 1'b1 || hold !== 1'b1 || frame_done !== 1'b0)
         $display("[TB] FAIL bad_pid_error: got err=%b hold=%b done=%b, required err=1 hold=1 done=0",
                  frame_error, hold, frame_done);
      else passes++;
      idle_cycle();
      checks++;
      if (frame_error !== 1'b0 || hold !== 1'b0 || processor_id !== 4'd9 || prog_data !== 8'h00)
         $display("[TB] FAIL bad_pid_after: got err=%b hold=%b id=%0d data=%h, required err=0 hold=0 id=9 data=00",
                  frame_error, hold, processor_id, prog_data);
      else passes++;
   endtask

   task automatic test_reserved_instr();
      send_byte(8'hC1);
      send_byte(8'd0);
      send_byte(8'h55);
      checks++;
      if (frame_error !== 1'b1 || processor_id !== 4'd9)
         $display("[TB] FAIL reserved_error: got err=%b id=%0d, required err=1 id=9", frame_error, processor_id);
      else passes++;
      idle_cycle();
      checks++;
      if (hold !== 1'b0 || frame_error !== 1'b0)
         $display("[TB] FAIL reserved_after: got hold=%b err=%b, required 0 0", hold, frame_error);
      else passes++;
   endtask

   task automatic test_valid_gap();
      send_byte(8'h82);
      send_byte(8'd1);
      expect_word(3'd4, 4'd1, 8'hA5, 1'b0);
      send_byte(8'hA5);
      for (int i = 0; i < 5; i++) begin
         idle_cycle();
         checks++;
         if (hold !== 1'b1 || in_ready !== 1'b1 || instruction !== INSTR_NOP)
            $display("[TB] FAIL gap_cycle%0d: got hold=%b rdy=%b instr=%0d, required 1 1 0",
                     i, hold, in_ready, instruction);
         else passes++;
      end
      expect_word(3'd4, 4'd1, 8'h5A, 1'b1);
      send_byte(8'h5A);
      idle_cycle();
      checks++;
      if (hold !== 1'b0 || sb.size() != 0)
         $display("[TB] FAIL gap_end: got hold=%b pending=%0d, required hold=0 pending=0", hold, sb.size());
      else passes++;
   endtask

   task automatic test_back_to_back();
      send_byte(8'h21);
      send_byte(8'd4);
      expect_word(3'd1, 4'd4, 8'h99, 1'b1);
      send_byte(8'h99);
      send_byte(8'h61);
      checks++;
      if (hold !== 1'b1) $display("[TB] FAIL b2b_hold: got %b, required 1", hold);
      else passes++;
      send_byte(8'd6);
      expect_word(3'd3, 4'd6, 8'hAB, 1'b1);
      send_byte(8'hAB);
      idle_cycle();
      checks++;
      if (hold !== 1'b0 || sb.size() != 0)
         $display("[TB] FAIL b2b_end: got hold=%b pending=%0d, required hold=0 pending=0", hold, sb.size());
      else passes++;
   endtask

   task automatic test_reset_mid_frame();
      send_byte(8'h23);
      send_byte(8'd2);
      expect_word(3'd1, 4'd2, 8'h11, 1'b0);
      send_byte(8'h11);
      #2;
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if ({in_ready, hold, frame_done, frame_error, processor_id, prog_data, 3'(instruction)} !== 19'd0)
         $display("[TB] FAIL mid_frame_reset: got rdy=%b hold=%b id=%0d data=%h instr=%0d, required all 0",
                  in_ready, hold, processor_id, prog_data, instruction);
      else passes++;
      @(negedge clock_fast);
      reset = 1'b1;
      @(negedge clock_fast);
      send_byte(8'h42);
      send_byte(8'd5);
      expect_word(3'd2, 4'd5, 8'h77, 1'b0);
      send_byte(8'h77);
      expect_word(3'd2, 4'd5, 8'h88, 1'b1);
      send_byte(8'h88);
      idle_cycle();
      checks++;
      if (hold !== 1'b0 || sb.size() != 0)
         $display("[TB] FAIL post_reset_frame: got hold=%b pending=%0d, required hold=0 pending=0", hold, sb.size());
      else passes++;
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_two_word();
      test_zero_count();
      test_bad_pid();
      test_reserved_instr();
      test_valid_gap();
      test_back_to_back();
      test_reset_mid_frame();
      repeat (2) @(negedge clock_fast);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
